// File: rtl/uart_pkg.sv
// Shared UART definitions: parser state encoding and default constants
// used by the receiver, transmitter and frame parser.
package uart_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE      = 8'hA5;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 50000;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK,
        HOLD
    } parser_state_t;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear.
// Ports: clk, reset, clear, enable in; expired out (count reached limit).
module byte_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count;

    assign expired = (count == LIMIT);

    // Saturate at the limit so the count never wraps while waiting
    // for the parser to leave the frame.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: SYNC_BYTE, PAYLOAD_LEN payload bytes, XOR checksum byte.
// Ports: clk, reset, rx_data/rx_valid in; frame_data/frame_valid/frame_ready
// handshake; csum_err, timeout_err, overrun_err one-cycle pulses.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         PAYLOAD_LEN    = 2,
    parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [8*PAYLOAD_LEN-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     csum_err,
    output logic                     timeout_err,
    output logic                     overrun_err
);

    localparam int W  = 8 * PAYLOAD_LEN;
    localparam int CW = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_LEN - 1);

    parser_state_t state;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    csum;
    logic [W-1:0]  shadow;
    logic [W+7:0]  shifted;
    logic          active;
    logic          timer_clear;
    logic          expired;

    // New byte enters at the LSB so the first byte ends up in the MSBs.
    assign shifted     = {shadow, rx_data};
    assign active      = (state == PAYLOAD) || (state == CHECK);
    assign timer_clear = !active || rx_valid;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (active),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            csum        <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            csum_err    <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            csum_err    <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state    <= PAYLOAD;
                        byte_cnt <= '0;
                        csum     <= '0;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        shadow   <= shifted[W-1:0];
                        csum     <= csum ^ rx_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST) begin
                            state <= CHECK;
                        end
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        byte_cnt    <= '0;
                        csum        <= '0;
                        state       <= IDLE;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            frame_data  <= shadow;
                            frame_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            csum_err <= 1'b1;
                            state    <= IDLE;
                        end
                        byte_cnt <= '0;
                        csum     <= '0;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        byte_cnt    <= '0;
                        csum        <= '0;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    // A byte in the handshake cycle is judged as if in IDLE.
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state    <= PAYLOAD;
                            byte_cnt <= '0;
                            csum     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rx_valid) begin
                        overrun_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser (PAYLOAD_LEN=2, short timeout).
// Table-driven frames plus hand sequences; frame scoreboard on a queue.
module tb_uart_frame_parser;

    localparam int T = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        csum_err;
    logic        timeout_err;
    logic        overrun_err;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .SYNC_BYTE     (8'hA5),
        .PAYLOAD_LEN   (2),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .csum_err   (csum_err),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    int checks   = 0;
    int failures = 0;
    int csum_cnt = 0;
    int to_cnt   = 0;
    int ov_cnt   = 0;
    logic [15:0] exp_q[$];
    logic fv_q = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] bytes;
        int          n;
        bit          good;
        bit          cerr;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each rising frame_valid pops one expected payload.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid && !fv_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got %0h expected none",
                             frame_data);
                end else begin
                    chk("sb_frame_data", 32'(frame_data),
                        32'(exp_q.pop_front()));
                end
            end
            if (csum_err)    csum_cnt++;
            if (timeout_err) to_cnt++;
            if (overrun_err) ov_cnt++;
        end
        fv_q = frame_valid;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            if (i == v.n - 1 && v.good) exp_q.push_back(v.data);
            send_byte(v.bytes[31-8*i -: 8]);
        end
        chk({v.name, "_fv"}, 32'(frame_valid), 32'(v.good));
        chk({v.name, "_cerr"}, 32'(csum_err), 32'(v.cerr));
        idle(1);
        chk({v.name, "_fv_drop"}, 32'(frame_valid), 32'd0);
        chk({v.name, "_cerr_end"}, 32'(csum_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"good3c12", 32'hA53C122E, 4, 1'b1, 1'b0, 16'h3C12};
        vecs[1] = '{"badcsum",  32'hA53C122F, 4, 1'b0, 1'b1, 16'h0000};
        vecs[2] = '{"good55aa", 32'hA555AAFF, 4, 1'b1, 1'b0, 16'h55AA};
        vecs[3] = '{"junk",     32'h00FF0000, 2, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{"syncdata", 32'hA5A5A500, 4, 1'b1, 1'b0, 16'hA5A5};
        vecs[5] = '{"good0102", 32'hA5010203, 4, 1'b1, 1'b0, 16'h0102};

        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_fd", 32'(frame_data), 32'd0);
        chk("rst_errs", {29'd0, csum_err, timeout_err, overrun_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Timeout after A5,3C, then a clean frame.
        send_byte(8'hA5);
        send_byte(8'h3C);
        begin
            int n = 0;
            while (!timeout_err && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("timeout_latency", 32'(n), 32'(T + 1));
        end
        idle(1);
        chk("timeout_pulse_end", 32'(timeout_err), 32'd0);
        chk("timeout_fv", 32'(frame_valid), 32'd0);
        run_vec(vecs[5]);

        // Held frame, overrun byte, then handshake.
        @(negedge clk);
        frame_ready = 1'b0;
        exp_q.push_back(16'h1122);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("hold_fv", 32'(frame_valid), 32'd1);
        idle(3);
        chk("hold_fv_stable", 32'(frame_valid), 32'd1);
        send_byte(8'h77);
        chk("overrun_pulse", 32'(overrun_err), 32'd1);
        chk("overrun_fv", 32'(frame_valid), 32'd1);
        chk("overrun_fd", 32'(frame_data), 32'h1122);
        idle(1);
        chk("overrun_pulse_end", 32'(overrun_err), 32'd0);
        @(negedge clk);
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("handshake_fv_drop", 32'(frame_valid), 32'd0);

        // SYNC arriving in the handshake cycle starts the next frame.
        @(negedge clk);
        frame_ready = 1'b0;
        exp_q.push_back(16'h5AA5);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'hFF);
        chk("hs_sync_hold", 32'(frame_valid), 32'd1);
        @(negedge clk);
        frame_ready = 1'b1;
        rx_data     = 8'hA5;
        rx_valid    = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("hs_sync_fv_drop", 32'(frame_valid), 32'd0);
        chk("hs_sync_no_overrun", 32'(overrun_err), 32'd0);
        exp_q.push_back(16'h3C12);
        send_byte(8'h3C);
        send_byte(8'h12);
        send_byte(8'h2E);
        chk("hs_sync_frame", 32'(frame_valid), 32'd1);
        chk("hs_sync_fd", 32'(frame_data), 32'h3C12);
        idle(1);

        // Reset mid-frame, with a byte presented during reset.
        send_byte(8'hA5);
        send_byte(8'h3C);
        @(negedge clk);
        reset    = 1'b1;
        rx_data  = 8'h12;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("midrst_fv", 32'(frame_valid), 32'd0);
        chk("midrst_fd", 32'(frame_data), 32'd0);
        chk("midrst_errs", {29'd0, csum_err, timeout_err, overrun_err},
            32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0]);

        idle(2);
        chk("csum_err_count", 32'(csum_cnt), 32'd1);
        chk("timeout_err_count", 32'(to_cnt), 32'd1);
        chk("overrun_err_count", 32'(ov_cnt), 32'd1);
        chk("sb_pending", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
